peripheral_responder: RTL and testbench
=======================================

# peripheral_responder

Core-facing end of the RISC_V_Core peripheral port: consumes the request triple `to_peripheral` / `to_peripheral_data` / `to_peripheral_valid` and produces the response triple `from_peripheral` / `from_peripheral_data` / `from_peripheral_valid`. It bridges the core to a host-side byte/word stream through two FIFOs: an RX FIFO from host to core and a TX FIFO from core to host. It sits beside the core in the top level and in every peripheral-exercising testbench, replacing the tied-off peripheral inputs.

## Interface
- `DATA_WIDTH`, 32: width of request/response data and FIFO words.
- `FIFO_DEPTH`, 8: entries per FIFO; power of 2, 2..128.
- `TIMEOUT`, 255: cycles a blocking READ waits for RX data; 1..65535.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low; `reset==0` at a rising edge resets the block.
- `to_peripheral` in 2: request opcode.
- `to_peripheral_data` in DATA_WIDTH: request payload (WRITE only).
- `to_peripheral_valid` in 1: request strobe, one cycle per request.
- `from_peripheral` out 2: response code.
- `from_peripheral_data` out DATA_WIDTH: response payload.
- `from_peripheral_valid` out 1: one-cycle response strobe.
- `host_rx_valid` in 1, `host_rx_data` in DATA_WIDTH, `host_rx_ready` out 1: host→core stream.
- `host_tx_valid` out 1, `host_tx_data` out DATA_WIDTH, `host_tx_ready` in 1: core→host stream.
- `protocol_error` out 1: sticky; set when a request arrives while busy.

## Operation
- Request opcodes: 00 NOP, 01 WRITE, 10 READ, 11 STATUS.
- Response codes: 00 NONE, 01 ACK, 10 DATA, 11 ERROR.
- FSM states: IDLE, WAIT_RX. Requests are accepted only in IDLE.
- NOP: no response.
- WRITE: if TX is not full, push the payload and respond ACK with data 0. If TX is full, drop the payload and respond ERROR with data 1.
- READ with RX non-empty: pop and respond DATA with the popped word.
- READ with RX empty: go to WAIT_RX and load the counter with TIMEOUT.
  - In WAIT_RX, the first cycle RX is non-empty: pop, respond DATA, return to IDLE.
  - Otherwise the counter decrements each cycle; when it reaches 0, respond ERROR with data 2 and return to IDLE.
- STATUS: respond DATA with data[15:8] = TX count, data[7:0] = RX count, all other bits 0. Counts are zero-extended.
- `to_peripheral_valid` in WAIT_RX: the request is ignored (no response) and `protocol_error` sets. It clears only on reset.
- Host-side FIFO handshakes:
  - `host_rx_ready = !rx_full`; a push occurs on `host_rx_valid && host_rx_ready`.
  - `host_tx_valid = !tx_empty`; `host_tx_data` is the TX head; a pop occurs on `host_tx_valid && host_tx_ready`.
- Simultaneous push and pop on the same FIFO are both honoured; the count is unchanged.
- No fall-through: a word pushed in cycle k is poppable from cycle k+1.

## Timing
- Reset values:
  - `from_peripheral` = 00, `from_peripheral_data` = 0, `from_peripheral_valid` = 0.
  - `host_rx_ready` = 1, `host_tx_valid` = 0, `protocol_error` = 0.
  - FSM in IDLE, both FIFOs empty, counter = 0.
- All core-facing outputs are registered.
- `from_peripheral`/`from_peripheral_data` are 00/0 in every cycle where valid is low.
- Immediate responses (WRITE, non-blocking READ, STATUS) appear exactly 1 cycle after the accepting edge.
- Blocking READ: the response appears 1 cycle after the pop edge.
- Timeout ERROR appears TIMEOUT+1 cycles after the accepting edge.
- The TX count seen by STATUS and host side reflects a WRITE from the cycle after that WRITE is accepted.
- Reset in WAIT_RX: return to IDLE, flush both FIFOs, no response issued.
- Back-to-back requests in IDLE (every cycle) are all served at 1-cycle latency.

## Structure
- Package `peripheral_pkg`: opcode constants, response-code constants, error data codes (1 = TX full, 2 = RX timeout), FSM state encoding.
- Sub-module `sync_fifo` (DATA_WIDTH, DEPTH): synchronous FIFO with full/empty/count outputs and the same active-low synchronous reset. It is instantiated twice (RX, TX).
- The top level holds the FSM, timeout counter, response registers and error flag.

## Test plan
- Reset, then WRITE 0xDEADBEEF with `host_tx_ready=1` → cycle+1: ACK/0. `host_tx_valid` with data 0xDEADBEEF; popped the same cycle.
- Fill TX with 8 WRITEs (`host_tx_ready=0`), then a 9th WRITE → responses 1–8 ACK, 9th ERROR data 1. STATUS → DATA 0x00000800.
- Host pushes 0x12345678, then READ → DATA 0x12345678 at cycle+1. A second READ waits; the host pushes 0xA5A5A5A5 10 cycles later → DATA 0xA5A5A5A5 one cycle after the pop.
- READ on empty RX with TIMEOUT=4 → ERROR data 2 exactly 5 cycles after the request. A request issued during the wait → no response, `protocol_error`=1.
- Drive `reset`=0 mid-WAIT_RX with FIFOs partly full → next cycle all outputs at reset values and STATUS returns 0.
- Host pushes while the core pops RX at count 8 (full) → the push is blocked by `host_rx_ready`=0. At count 3, simultaneous push/pop leaves count 3.

Source files
------------

// File: rtl/peripheral_pkg.sv
// Shared definitions for the peripheral responder.
// Holds the request opcodes, the response codes, the error payload codes
// and the FSM state encoding. The top level and the testbench import it.
package peripheral_pkg;

  // Request opcodes on to_peripheral
  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_READ   = 2'b10;
  localparam logic [1:0] OP_STATUS = 2'b11;

  // Response codes on from_peripheral
  localparam logic [1:0] RSP_NONE  = 2'b00;
  localparam logic [1:0] RSP_ACK   = 2'b01;
  localparam logic [1:0] RSP_DATA  = 2'b10;
  localparam logic [1:0] RSP_ERROR = 2'b11;

  // Payload carried by an ERROR response
  localparam logic [7:0] ERR_TX_FULL    = 8'd1;
  localparam logic [7:0] ERR_RX_TIMEOUT = 8'd2;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_WAIT_RX = 1'b1
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous single-clock FIFO with registered head (no fall-through).
// A word pushed at one edge becomes visible on pop_data after that edge.
// Ports:
//   clock, reset      - rising-edge clock, synchronous active-low reset
//   push, push_data   - write strobe and word; ignored while full
//   pop, pop_data     - read strobe and current head word; ignored while empty
//   full, empty       - occupancy flags
//   count             - number of stored words (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   push_data,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   pop_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  push_ok, pop_ok;

  assign full     = (count_q == FULL_COUNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem[rd_ptr_q];

  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    // Push and pop in the same cycle leave the occupancy unchanged
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only; a reset empties the FIFO through the pointers
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/peripheral_responder.sv
// Core-facing end of the RISC_V_Core peripheral port.
// Decodes one request per cycle from the core and answers with a registered
// one-cycle response strobe. WRITE feeds the TX FIFO towards the host, READ
// drains the RX FIFO filled by the host (waiting up to TIMEOUT cycles when it
// is empty), STATUS reports both FIFO occupancies.
// Ports:
//   clock, reset                 - rising-edge clock, synchronous active-low reset
//   to_peripheral[_data,_valid]  - core request opcode, payload, strobe
//   from_peripheral[_data,_valid]- registered response code, payload, strobe
//   host_rx_valid/data/ready     - host -> core stream into the RX FIFO
//   host_tx_valid/data/ready     - core -> host stream out of the TX FIFO
//   protocol_error               - sticky flag: request seen while waiting for RX
// DATA_WIDTH must be at least 16 so both counts fit in the STATUS word.
module peripheral_responder
  import peripheral_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            to_peripheral,
  input  logic [DATA_WIDTH-1:0] to_peripheral_data,
  input  logic                  to_peripheral_valid,
  output logic [1:0]            from_peripheral,
  output logic [DATA_WIDTH-1:0] from_peripheral_data,
  output logic                  from_peripheral_valid,
  input  logic                  host_rx_valid,
  input  logic [DATA_WIDTH-1:0] host_rx_data,
  output logic                  host_rx_ready,
  output logic                  host_tx_valid,
  output logic [DATA_WIDTH-1:0] host_tx_data,
  input  logic                  host_tx_ready,
  output logic                  protocol_error
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] TIMEOUT_LOAD = 16'(TIMEOUT);

  state_e                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [1:0]            rsp_code_q, rsp_code_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  perr_q, perr_d;

  logic                  rx_full, rx_empty, rx_pop;
  logic [CW-1:0]         rx_count;
  logic [DATA_WIDTH-1:0] rx_head;
  logic                  tx_full, tx_empty, tx_push, tx_pop;
  logic [CW-1:0]         tx_count;

  function automatic logic [DATA_WIDTH-1:0] status_word(input logic [CW-1:0] tx_cnt,
                                                        input logic [CW-1:0] rx_cnt);
    logic [DATA_WIDTH-1:0] w;
    w       = '0;
    w[15:8] = 8'(tx_cnt);
    w[7:0]  = 8'(rx_cnt);
    return w;
  endfunction

  assign host_rx_ready = !rx_full;
  assign host_tx_valid = !tx_empty;
  assign tx_pop        = host_tx_valid && host_tx_ready;

  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (host_rx_valid),
    .push_data (host_rx_data),
    .pop       (rx_pop),
    .pop_data  (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (tx_push),
    .push_data (to_peripheral_data),
    .pop       (tx_pop),
    .pop_data  (host_tx_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_code_d  = RSP_NONE;
    rsp_data_d  = '0;
    perr_d      = perr_q;
    rx_pop      = 1'b0;
    tx_push     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (to_peripheral_valid) begin
          case (to_peripheral)
            OP_WRITE: begin
              rsp_valid_d = 1'b1;
              if (!tx_full) begin
                tx_push    = 1'b1;
                rsp_code_d = RSP_ACK;
              end else begin
                rsp_code_d = RSP_ERROR;
                rsp_data_d = DATA_WIDTH'(ERR_TX_FULL);
              end
            end
            OP_READ: begin
              if (!rx_empty) begin
                rx_pop      = 1'b1;
                rsp_valid_d = 1'b1;
                rsp_code_d  = RSP_DATA;
                rsp_data_d  = rx_head;
              end else begin
                state_d = ST_WAIT_RX;
                cnt_d   = TIMEOUT_LOAD;
              end
            end
            OP_STATUS: begin
              rsp_valid_d = 1'b1;
              rsp_code_d  = RSP_DATA;
              rsp_data_d  = status_word(tx_count, rx_count);
            end
            default: ;
          endcase
        end
      end

      ST_WAIT_RX: begin
        // Requests are not accepted here; they are dropped and flagged
        if (to_peripheral_valid) perr_d = 1'b1;
        if (!rx_empty) begin
          rx_pop      = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_code_d  = RSP_DATA;
          rsp_data_d  = rx_head;
          cnt_d       = '0;
          state_d     = ST_IDLE;
        end else if (cnt_q <= 16'd1) begin
          // The counter reaches zero at this edge, so the ERROR is
          // registered together with it: TIMEOUT edges after acceptance.
          rsp_valid_d = 1'b1;
          rsp_code_d  = RSP_ERROR;
          rsp_data_d  = DATA_WIDTH'(ERR_RX_TIMEOUT);
          cnt_d       = '0;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_code_q  <= RSP_NONE;
      rsp_data_q  <= '0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_code_q  <= rsp_code_d;
      rsp_data_q  <= rsp_data_d;
      perr_q      <= perr_d;
    end
  end

  assign from_peripheral       = rsp_code_q;
  assign from_peripheral_data  = rsp_data_q;
  assign from_peripheral_valid = rsp_valid_q;
  assign protocol_error        = perr_q;

endmodule

// File: tb/tb_peripheral_responder.sv
// Testbench for peripheral_responder: directed scenarios followed by random
// traffic, checked by a queue-based reference model and a negedge monitor.
module tb_peripheral_responder;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int TMO   = 12;

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    to_peripheral;
  logic [DW-1:0] to_peripheral_data;
  logic          to_peripheral_valid;
  logic [1:0]    from_peripheral;
  logic [DW-1:0] from_peripheral_data;
  logic          from_peripheral_valid;
  logic          host_rx_valid;
  logic [DW-1:0] host_rx_data;
  logic          host_rx_ready;
  logic          host_tx_valid;
  logic [DW-1:0] host_tx_data;
  logic          host_tx_ready;
  logic          protocol_error;

  peripheral_responder #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .to_peripheral         (to_peripheral),
    .to_peripheral_data    (to_peripheral_data),
    .to_peripheral_valid   (to_peripheral_valid),
    .from_peripheral       (from_peripheral),
    .from_peripheral_data  (from_peripheral_data),
    .from_peripheral_valid (from_peripheral_valid),
    .host_rx_valid         (host_rx_valid),
    .host_rx_data          (host_rx_data),
    .host_rx_ready         (host_rx_ready),
    .host_tx_valid         (host_tx_valid),
    .host_tx_data          (host_tx_data),
    .host_tx_ready         (host_tx_ready),
    .protocol_error        (protocol_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]    code;
    logic [DW-1:0] data;
  } rsp_t;

  // Reference model state: FIFO contents as queues, a pending blocking read
  // as a flag plus the edge number at which it times out.
  rsp_t          exp_q[$];
  logic [DW-1:0] rx_m[$];
  logic [DW-1:0] tx_m[$];
  bit            waiting = 1'b0;
  bit            perr_m  = 1'b0;
  int            edge_n  = 0;
  int            deadline = 0;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin : model
    int   rx_pre, tx_pre;
    bit   c_rx_pop, c_tx_push, h_rx_push, h_tx_pop;
    rsp_t r;
    edge_n++;
    if (!reset) begin
      rx_m.delete();
      tx_m.delete();
      exp_q.delete();
      waiting = 1'b0;
      perr_m  = 1'b0;
    end else begin
      rx_pre    = rx_m.size();
      tx_pre    = tx_m.size();
      c_rx_pop  = 1'b0;
      c_tx_push = 1'b0;
      h_rx_push = host_rx_valid && (rx_pre < DEPTH);
      h_tx_pop  = host_tx_ready && (tx_pre > 0);
      if (!waiting) begin
        if (to_peripheral_valid) begin
          case (to_peripheral)
            2'b01: begin
              if (tx_pre < DEPTH) begin
                c_tx_push = 1'b1;
                r.code = 2'b01; r.data = 0;
              end else begin
                r.code = 2'b11; r.data = 1;
              end
              exp_q.push_back(r);
            end
            2'b10: begin
              if (rx_pre > 0) c_rx_pop = 1'b1;
              else begin
                waiting  = 1'b1;
                deadline = edge_n + TMO;
              end
            end
            2'b11: begin
              r.code = 2'b10;
              r.data = tx_pre * 256 + rx_pre;
              exp_q.push_back(r);
            end
            default: ;
          endcase
        end
      end else begin
        if (to_peripheral_valid) perr_m = 1'b1;
        if (rx_pre > 0) begin
          c_rx_pop = 1'b1;
          waiting  = 1'b0;
        end else if (edge_n == deadline) begin
          r.code = 2'b11; r.data = 2;
          exp_q.push_back(r);
          waiting = 1'b0;
        end
      end
      if (c_rx_pop) begin
        r.code = 2'b10;
        r.data = rx_m.pop_front();
        exp_q.push_back(r);
      end
      if (h_tx_pop)  void'(tx_m.pop_front());
      if (h_rx_push) rx_m.push_back(host_rx_data);
      if (c_tx_push) tx_m.push_back(to_peripheral_data);
    end
  end

  always @(negedge clock) begin : monitor
    rsp_t r;
    chk("rsp_valid", {31'd0, from_peripheral_valid}, {31'd0, exp_q.size() != 0});
    if (from_peripheral_valid && exp_q.size() != 0) begin
      r = exp_q.pop_front();
      chk("rsp_code", {30'd0, from_peripheral}, {30'd0, r.code});
      chk("rsp_data", from_peripheral_data, r.data);
    end else begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      if (!from_peripheral_valid) begin
        chk("idle_code", {30'd0, from_peripheral}, 32'd0);
        chk("idle_data", from_peripheral_data, 32'd0);
      end
    end
    chk("host_rx_ready", {31'd0, host_rx_ready}, {31'd0, rx_m.size() < DEPTH});
    chk("host_tx_valid", {31'd0, host_tx_valid}, {31'd0, tx_m.size() > 0});
    if (tx_m.size() > 0) chk("host_tx_data", host_tx_data, tx_m[0]);
    chk("protocol_error", {31'd0, protocol_error}, {31'd0, perr_m});
  end

  task automatic cyc(input bit v, input logic [1:0] op, input logic [DW-1:0] d,
                     input bit rxv, input logic [DW-1:0] rxd, input bit txr);
    to_peripheral_valid = v;
    to_peripheral       = op;
    to_peripheral_data  = d;
    host_rx_valid       = rxv;
    host_rx_data        = rxd;
    host_tx_ready       = txr;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n, input bit txr);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, 32'd0, 1'b0, 32'd0, txr);
  endtask

  initial begin
    reset = 1'b0;
    to_peripheral_valid = 1'b0;
    to_peripheral = 2'b00;
    to_peripheral_data = '0;
    host_rx_valid = 1'b0;
    host_rx_data = '0;
    host_tx_ready = 1'b0;
    idle(3, 1'b0);
    reset = 1'b1;
    idle(2, 1'b0);

    // Single WRITE with the host ready: ACK/0, word pops out to host
    cyc(1'b1, 2'b01, 32'hDEADBEEF, 1'b0, 32'd0, 1'b1);
    idle(3, 1'b1);

    // Fill TX, overflow once, then STATUS (expected 0x00000800), drain
    for (int i = 0; i < 9; i++) cyc(1'b1, 2'b01, 32'h1000 + i, 1'b0, 32'd0, 1'b0);
    cyc(1'b1, 2'b11, 32'd0, 1'b0, 32'd0, 1'b0);
    idle(10, 1'b1);

    // Non-blocking READ, then blocking READ satisfied 10 cycles later
    cyc(1'b0, 2'b00, 32'd0, 1'b1, 32'h12345678, 1'b1);
    cyc(1'b1, 2'b10, 32'd0, 1'b0, 32'd0, 1'b1);
    cyc(1'b1, 2'b10, 32'd0, 1'b0, 32'd0, 1'b1);
    idle(9, 1'b1);
    cyc(1'b0, 2'b00, 32'd0, 1'b1, 32'hA5A5A5A5, 1'b1);
    idle(3, 1'b1);

    // READ on empty RX times out; a STATUS during the wait is dropped
    cyc(1'b1, 2'b10, 32'd0, 1'b0, 32'd0, 1'b1);
    idle(3, 1'b1);
    cyc(1'b1, 2'b11, 32'd0, 1'b0, 32'd0, 1'b1);
    idle(TMO + 2, 1'b1);

    // Reset while waiting with TX partly full, then STATUS reads zero
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'b01, 32'h2000 + i, 1'b0, 32'd0, 1'b0);
    cyc(1'b1, 2'b10, 32'd0, 1'b0, 32'd0, 1'b0);
    idle(2, 1'b0);
    reset = 1'b0;
    idle(1, 1'b0);
    reset = 1'b1;
    cyc(1'b1, 2'b11, 32'd0, 1'b0, 32'd0, 1'b0);
    idle(2, 1'b0);

    // RX full blocks host pushes, even alongside a core pop
    for (int i = 0; i < 9; i++) cyc(1'b0, 2'b00, 32'd0, 1'b1, 32'h3000 + i, 1'b0);
    cyc(1'b1, 2'b11, 32'd0, 1'b0, 32'd0, 1'b0);
    cyc(1'b1, 2'b10, 32'd0, 1'b1, 32'h3999, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 2'b10, 32'd0, 1'b0, 32'd0, 1'b0);
    // Count is 3: push and pop together keep it at 3
    cyc(1'b1, 2'b10, 32'd0, 1'b1, 32'h4444, 1'b0);
    cyc(1'b1, 2'b11, 32'd0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'b10, 32'd0, 1'b0, 32'd0, 1'b0);
    idle(2, 1'b1);

    // Random traffic, including back-to-back requests and occasional reset
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 149) != 0);
      cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
          ($urandom_range(0, 2) == 0), $urandom, 1'($urandom_range(0, 1)));
    end
    reset = 1'b1;
    idle(TMO + 4, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
